shadow_copy_ctrl: RTL and testbench
===================================

# shadow_copy_ctrl

Boot-time sequencer and bus owner for the 64k shadowed main memory. After reset it copies the low ROM window (Addr[15]=0) byte-by-byte into the RAM window (Addr[15]=1), holding the CPU off the memory bridge. It then hands the bridge to the CPU as a transparent pass-through. It replaces the initial-block preload used in simulation with the real hardware copy sequence.

## Interface

- COPY_WORDS, 32768: bytes copied; legal range 1..32768. Source is {0,i[14:0]}, destination is {1,i[14:0]}.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- Copy_Start  in  1  pulse high for 1 cycle in DONE to re-run the copy; ignored in other states
- Cpu_Addr  in  16  CPU address
- Cpu_MemBridge_Load  in  1  CPU write strobe, active low
- Cpu_MemBridge_Direction  in  1  CPU read enable, high = memory drives bus
- Cpu_Memory_Ack  in  1  CPU ack, active low
- Cpu_DataOut  in  8  CPU write data
- Cpu_DataDrive  in  1  CPU drives data toward memory
- Mem_DataIn  in  8  memory bus sampled value
- Mem_Addr  out  16  address to memory
- Mem_MemBridge_Load  out  1  write strobe to memory, active low
- Mem_MemBridge_Direction  out  1  memory output enable
- Mem_Memory_Ack  out  1  ack to memory, active low
- Mem_DataOut  out  8  write data to memory
- Mem_DataDrive  out  1  enable for the external bus driver
- Cpu_Hold  out  1  high while the controller owns the bridge
- Copy_Done  out  1  high in DONE
- Copy_Count  out  15  index of the byte currently being copied

## Operation

- States: RD, LATCH, WSETUP, WSTROBE, WHOLD, DONE. Async reset enters RD with count=0.
- RD: Mem_Addr={0,count}; Direction=1; Load=1; DataDrive=0. Next state is LATCH.
- LATCH: same outputs as RD. The data register captures Mem_DataIn at the end of the cycle. Next state is WSETUP.
- WSETUP: Mem_Addr={1,count}; Direction=0; DataDrive=1; Mem_DataOut=data register; Load=1. Next state is WSTROBE.
- WSTROBE: same as WSETUP with Load=0. Next state is WHOLD.
- WHOLD: same as WSETUP (Load=1, data still driven). This gives address and data hold after the strobe rises.
  - If count==COPY_WORDS-1, go to DONE.
  - Otherwise count increments and the next state is RD.
- DONE: pure combinational pass-through of every Cpu_* input to its Mem_* output.
  - Cpu_Hold=0; Copy_Done=1; count is held.
  - Copy_Start=1 sets count to 0 and goes to RD.
- Outside DONE: Cpu_Hold=1; Copy_Done=0; Mem_Memory_Ack=1; all CPU inputs are ignored.
- Direction and DataDrive are never high in the same cycle, including across state transitions. The memory-side invalid-command debug flag must never assert.
- Count is 15 bits. With COPY_WORDS=32768 the last index is 0x7FFF, and the count does not wrap before the transition to DONE.

## Timing

- Fixed 5 cycles per byte. Full copy = 5*COPY_WORDS cycles from reset release to Copy_Done=1 (163840 at default).
- All Mem_* controls are registered or state-decoded, so they are glitch-free within the copy sequence.
- The DONE path is combinational: 0 cycles of latency from CPU to memory.
- Reset values (asserted immediately, asynchronously):
  - state=RD, count=0, data register=0x00
  - Mem_Addr=0x0000, Direction=1, Load=1, Ack=1, DataDrive=0, Mem_DataOut=0x00
  - Cpu_Hold=1, Copy_Done=0
- Reset mid-copy, including during WSTROBE: Load returns to 1 immediately and the copy restarts from byte 0. A byte partially written before the reset is rewritten.
- Reset and Copy_Start in the same cycle: reset wins.
- Copy_Start held high for multiple cycles: only the cycle in DONE is acted on. The copy then runs to completion regardless of Copy_Start.

## Test plan

- Reset release, COPY_WORDS=4, ROM bytes 0x11,0x22,0x33,0x44 -> RAM 0x8000..0x8003 read back as 0x11,0x22,0x33,0x44; Copy_Done rises exactly 20 cycles after reset release.
- Bus monitor during the full copy -> Load=0 only when Mem_Addr[15]=1 and DataDrive=1; Direction and DataDrive never high together; exactly 4 write strobes, each lasting 1 cycle.
- In DONE, CPU writes 0xA5 to 0x8002 and then reads 0x8002 -> Mem_* outputs mirror CPU inputs in the same cycle; readback is 0xA5; Cpu_Hold=0.
- CPU activity during the copy (Cpu_MemBridge_Load=0 at 0x8001) -> ignored; RAM 0x8001 still reads 0x22; Cpu_Hold=1 throughout.
- Assert reset in the WSTROBE of byte 2 -> Load returns to 1 asynchronously; outputs match the reset values; the copy completes 20 cycles after release with correct data.
- Copy_Start pulse in DONE after the ROM model changes to 0xF0..0xF3 -> Copy_Done=0 for 20 cycles; RAM then reads 0xF0..0xF3.

Source files
------------

// File: rtl/shadow_copy_ctrl.sv
// Boot-time ROM-to-RAM shadow copier that owns the memory bridge until the copy
// finishes, then passes the CPU straight through to memory.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_RD    | present ROM address {0,count}, memory drives bus
// ST_LATCH | same as ST_RD, capture Mem_DataIn into data register
// ST_WSETUP| present RAM address {1,count}, drive data, strobe idle
// ST_WSTRB | write strobe low for one cycle
// ST_WHOLD | strobe high, address/data held; advance or finish
// ST_DONE  | combinational CPU pass-through, wait for Copy_Start
module shadow_copy_ctrl #(
  parameter int COPY_WORDS = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Copy_Start,
  input  logic [15:0] Cpu_Addr,
  input  logic        Cpu_MemBridge_Load,
  input  logic        Cpu_MemBridge_Direction,
  input  logic        Cpu_Memory_Ack,
  input  logic [7:0]  Cpu_DataOut,
  input  logic        Cpu_DataDrive,
  input  logic [7:0]  Mem_DataIn,
  output logic [15:0] Mem_Addr,
  output logic        Mem_MemBridge_Load,
  output logic        Mem_MemBridge_Direction,
  output logic        Mem_Memory_Ack,
  output logic [7:0]  Mem_DataOut,
  output logic        Mem_DataDrive,
  output logic        Cpu_Hold,
  output logic        Copy_Done,
  output logic [14:0] Copy_Count
);

  typedef enum logic [2:0] {
    ST_RD, ST_LATCH, ST_WSETUP, ST_WSTRB, ST_WHOLD, ST_DONE
  } state_t;

  localparam logic [14:0] LAST_IDX = 15'(COPY_WORDS - 1);

  state_t      state_q, state_d;
  logic [14:0] count_q, count_d;
  logic [7:0]  data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RD;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    count_d                 = count_q;
    data_d                  = data_q;
    Mem_Addr                = {1'b0, count_q};
    Mem_MemBridge_Load      = 1'b1;
    Mem_MemBridge_Direction = 1'b1;
    Mem_Memory_Ack          = 1'b1;
    Mem_DataOut             = data_q;
    Mem_DataDrive           = 1'b0;
    Cpu_Hold                = 1'b1;
    Copy_Done               = 1'b0;

    case (state_q)
      ST_RD: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        data_d  = Mem_DataIn;
        state_d = ST_WSETUP;
      end
      ST_WSETUP, ST_WSTRB, ST_WHOLD: begin
        Mem_Addr                = {1'b1, count_q};
        Mem_MemBridge_Direction = 1'b0;
        Mem_DataDrive           = 1'b1;
        if (state_q == ST_WSETUP) begin
          state_d = ST_WSTRB;
        end else if (state_q == ST_WSTRB) begin
          Mem_MemBridge_Load = 1'b0;
          state_d            = ST_WHOLD;
        end else if (count_q == LAST_IDX) begin
          // Compare before incrementing so a full 32768-byte copy never wraps.
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 15'd1;
          state_d = ST_RD;
        end
      end
      ST_DONE: begin
        Mem_Addr                = Cpu_Addr;
        Mem_MemBridge_Load      = Cpu_MemBridge_Load;
        Mem_MemBridge_Direction = Cpu_MemBridge_Direction;
        Mem_Memory_Ack          = Cpu_Memory_Ack;
        Mem_DataOut             = Cpu_DataOut;
        Mem_DataDrive           = Cpu_DataDrive;
        Cpu_Hold                = 1'b0;
        Copy_Done               = 1'b1;
        if (Copy_Start) begin
          count_d = '0;
          state_d = ST_RD;
        end
      end
      default: begin
        state_d = ST_RD;
        count_d = '0;
      end
    endcase
  end

  assign Copy_Count = count_q;

endmodule

// File: tb/tb_shadow_copy_ctrl.sv
// Self-checking bench for shadow_copy_ctrl: 64k byte memory model, bus monitor,
// table-driven pass-through vectors and randomized copy runs.
module tb_shadow_copy_ctrl;

  localparam int NW = 4;

  logic        clk;
  logic        reset;
  logic        Copy_Start;
  logic [15:0] Cpu_Addr;
  logic        Cpu_MemBridge_Load;
  logic        Cpu_MemBridge_Direction;
  logic        Cpu_Memory_Ack;
  logic [7:0]  Cpu_DataOut;
  logic        Cpu_DataDrive;
  logic [7:0]  Mem_DataIn;
  logic [15:0] Mem_Addr;
  logic        Mem_MemBridge_Load;
  logic        Mem_MemBridge_Direction;
  logic        Mem_Memory_Ack;
  logic [7:0]  Mem_DataOut;
  logic        Mem_DataDrive;
  logic        Cpu_Hold;
  logic        Copy_Done;
  logic [14:0] Copy_Count;

  shadow_copy_ctrl #(.COPY_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .Copy_Start(Copy_Start),
    .Cpu_Addr(Cpu_Addr), .Cpu_MemBridge_Load(Cpu_MemBridge_Load),
    .Cpu_MemBridge_Direction(Cpu_MemBridge_Direction), .Cpu_Memory_Ack(Cpu_Memory_Ack),
    .Cpu_DataOut(Cpu_DataOut), .Cpu_DataDrive(Cpu_DataDrive), .Mem_DataIn(Mem_DataIn),
    .Mem_Addr(Mem_Addr), .Mem_MemBridge_Load(Mem_MemBridge_Load),
    .Mem_MemBridge_Direction(Mem_MemBridge_Direction), .Mem_Memory_Ack(Mem_Memory_Ack),
    .Mem_DataOut(Mem_DataOut), .Mem_DataDrive(Mem_DataDrive), .Cpu_Hold(Cpu_Hold),
    .Copy_Done(Copy_Done), .Copy_Count(Copy_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: ROM window at 0x0000.., RAM window at 0x8000..
  logic [7:0] mem [0:65535];
  assign Mem_DataIn = Mem_MemBridge_Direction ? mem[Mem_Addr] : 8'h00;
  always @(posedge clk) begin
    if (Mem_MemBridge_Load === 1'b0) mem[Mem_Addr] <= Mem_DataOut;
  end

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int mon_err = 0;
  int hold_err = 0;
  bit prev_low = 1'b0;
  logic [7:0] exp_ram [NW];

  // bus rules while the controller owns the bridge
  always @(negedge clk) begin
    if (!reset && !Copy_Done) begin
      if (Mem_MemBridge_Direction && Mem_DataDrive) mon_err++;
      if (!Mem_MemBridge_Load) begin
        strobes++;
        if (Mem_Addr !== {1'b1, Copy_Count} || !Mem_DataDrive ||
            Mem_DataOut !== mem[{1'b0, Copy_Count}]) mon_err++;
        if (prev_low) mon_err++;
      end
      prev_low = !Mem_MemBridge_Load;
    end else begin
      prev_low = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cpu_idle();
    Cpu_Addr = 16'h0000; Cpu_MemBridge_Load = 1'b1; Cpu_MemBridge_Direction = 1'b0;
    Cpu_Memory_Ack = 1'b1; Cpu_DataOut = 8'h00; Cpu_DataDrive = 1'b0; Copy_Start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, Mem_Addr, 16'h0000);
    chk({tag, "_dir"}, Mem_MemBridge_Direction, 1'b1);
    chk({tag, "_load"}, Mem_MemBridge_Load, 1'b1);
    chk({tag, "_ack"}, Mem_Memory_Ack, 1'b1);
    chk({tag, "_dd"}, Mem_DataDrive, 1'b0);
    chk({tag, "_dout"}, Mem_DataOut, 8'h00);
    chk({tag, "_hold"}, Cpu_Hold, 1'b1);
    chk({tag, "_done"}, Copy_Done, 1'b0);
    chk({tag, "_count"}, Copy_Count, 15'd0);
  endtask

  // counts cycles until Copy_Done is seen, optionally with random CPU noise
  task automatic run_copy(input bit noise, output int cyc);
    cyc = 0;
    strobes = 0; mon_err = 0; hold_err = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (Copy_Done) break;
      if (!Cpu_Hold || Mem_Memory_Ack !== 1'b1) hold_err++;
      if (noise) begin
        Cpu_Addr = 16'($urandom); Cpu_MemBridge_Load = 1'($urandom);
        Cpu_MemBridge_Direction = 1'($urandom); Cpu_Memory_Ack = 1'($urandom);
        Cpu_DataOut = 8'($urandom); Cpu_DataDrive = 1'($urandom);
        Copy_Start = 1'($urandom);
      end
    end
    cpu_idle();
  endtask

  task automatic check_run(input string tag, input int cyc);
    chk({tag, "_cycles"}, cyc, 20);
    for (int i = 0; i < NW; i++) chk({tag, "_ram"}, mem[16'h8000 + i], exp_ram[i]);
    chk({tag, "_strobes"}, strobes, NW);
    chk({tag, "_bus_rules"}, mon_err, 0);
    chk({tag, "_hold"}, hold_err, 0);
  endtask

  task automatic load_rom(input logic [7:0] b0, b1, b2, b3);
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
    exp_ram[0] = b0; exp_ram[1] = b1; exp_ram[2] = b2; exp_ram[3] = b3;
    for (int i = 0; i < NW; i++) mem[16'h8000 + i] = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk); Copy_Start = 1'b1;
    @(negedge clk); Copy_Start = 1'b0;
    chk("start_done_low", Copy_Done, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a; logic ld; logic dir; logic ack; logic [7:0] d; logic dd;
    logic [15:0] ea; logic eld; logic edir; logic eack; logic [7:0] ed; logic edd;
  } vec_t;

  vec_t tbl [4];
  int cyc;
  bit found;

  initial begin
    tbl[0] = '{16'h8002, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[1] = '{16'h1234, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    tbl[2] = '{16'h8002, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h8002, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    cpu_idle();
    load_rom(8'h11, 8'h22, 8'h33, 8'h44);
    reset = 1'b1;
    #1 chk_reset_vals("por");

    // first copy with the CPU trying to write 0x8001 throughout
    @(negedge clk); reset = 1'b0;
    Cpu_Addr = 16'h8001; Cpu_MemBridge_Load = 1'b0; Cpu_DataOut = 8'h99;
    Cpu_DataDrive = 1'b1; Cpu_Memory_Ack = 1'b0;
    run_copy(1'b0, cyc);
    check_run("boot", cyc);
    chk("boot_hold_done", Cpu_Hold, 1'b0);

    // DONE pass-through vectors; write 0xA5 then read it back
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Cpu_Addr = tbl[i].a; Cpu_MemBridge_Load = tbl[i].ld; Cpu_MemBridge_Direction = tbl[i].dir;
      Cpu_Memory_Ack = tbl[i].ack; Cpu_DataOut = tbl[i].d; Cpu_DataDrive = tbl[i].dd;
      #1;
      chk("pt_addr", Mem_Addr, tbl[i].ea);
      chk("pt_load", Mem_MemBridge_Load, tbl[i].eld);
      chk("pt_dir", Mem_MemBridge_Direction, tbl[i].edir);
      chk("pt_ack", Mem_Memory_Ack, tbl[i].eack);
      chk("pt_dout", Mem_DataOut, tbl[i].ed);
      chk("pt_dd", Mem_DataDrive, tbl[i].edd);
      chk("pt_hold", Cpu_Hold, 1'b0);
      if (i == 2) chk("pt_readback", Mem_DataIn, 8'hA5);
    end
    cpu_idle();

    // restart after ROM changes, then randomized reruns with CPU noise
    load_rom(8'hF0, 8'hF1, 8'hF2, 8'hF3);
    pulse_start();
    run_copy(1'b0, cyc);
    check_run("restart", cyc);
    for (int r = 0; r < 3; r++) begin
      load_rom(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      pulse_start();
      run_copy(1'b1, cyc);
      check_run("rand", cyc);
    end

    // reset during the write strobe of byte 2
    load_rom(8'h11, 8'h22, 8'h33, 8'h44);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (Copy_Count == 15'd2 && Mem_MemBridge_Load == 1'b0) found = 1'b1;
    end
    chk("wstrobe_found", found, 1'b1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk); reset = 1'b0;
    run_copy(1'b0, cyc);
    check_run("midrst", cyc);

    // reset and Copy_Start together in DONE: reset wins
    load_rom(8'h5A, 8'hA5, 8'h0F, 8'hF0);
    @(negedge clk); reset = 1'b1; Copy_Start = 1'b1;
    #1 chk_reset_vals("rst_start");
    @(negedge clk); reset = 1'b0; Copy_Start = 1'b0;
    run_copy(1'b0, cyc);
    check_run("rst_start", cyc);

    // random pass-through: memory side must mirror the CPU in the same cycle
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      @(negedge clk);
      v.a = 16'($urandom); v.ld = 1'($urandom); v.dir = 1'($urandom);
      v.ack = 1'($urandom); v.d = 8'($urandom); v.dd = 1'($urandom);
      Cpu_Addr = v.a; Cpu_MemBridge_Load = v.ld; Cpu_MemBridge_Direction = v.dir;
      Cpu_Memory_Ack = v.ack; Cpu_DataOut = v.d; Cpu_DataDrive = v.dd;
      #1;
      chk("rpt_bus", {Mem_Addr, Mem_MemBridge_Load, Mem_MemBridge_Direction, Mem_Memory_Ack,
                      Mem_DataOut, Mem_DataDrive},
          {v.a, v.ld, v.dir, v.ack, v.d, v.dd});
      chk("rpt_done", Copy_Done, 1'b1);
    end
    cpu_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
